trade_dispatcher: RTL and testbench
===================================

# trade_dispatcher

Order-side initiator for the risk checker. Buffers strategy orders in a small FIFO and presents each one as a single-cycle trade request. It samples the approval one cycle later. Approved orders go to the exchange-facing output handshake and generate position/exposure update pulses back to the risk checker. Rejected orders are dropped and counted. The block sits between the strategy engine and the order-entry path.

## Interface
- FIFO_DEPTH, 4, order buffer entries; power of two, 2..16
- CNT_W, 16, width of the accept and reject counters
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  strategy order valid
- in_ready  out  1  FIFO not full
- in_qty  in  32  order quantity, unsigned
- in_notional  in  32  order notional, unsigned
- trade_data  out  32  quantity of the order under check
- trade_valid  out  1  one-cycle risk check request
- trade_approved  in  1  risk decision, valid the cycle after trade_valid
- out_valid  out  1  approved order presented to exchange path
- out_ready  in  1  exchange path accepts
- out_qty  out  32  approved quantity
- out_notional  out  32  approved notional
- position_update  out  32  equals out_qty on send
- position_update_valid  out  1  one-cycle pulse on send
- exposure_update  out  32  equals out_notional on send
- exposure_update_valid  out  1  one-cycle pulse on send
- accept_count  out  CNT_W  approved-and-sent orders, saturating
- reject_count  out  CNT_W  rejected orders, saturating

## Operation
- FIFO entry is {qty, notional}; 64 bits. Push on in_valid && in_ready. Pop on the IDLE->REQ transition.
- State IDLE: if the FIFO is non-empty, pop the head into a holding register and go to REQ.
- State REQ: trade_valid=1 and trade_data=held qty for exactly one cycle, then go to DECIDE.
- State DECIDE: sample trade_approved. If 1, go to SEND. If 0, increment reject_count and go to IDLE.
- State SEND: out_valid=1, with out_qty/out_notional taken from the holding register and held stable.
- On out_valid && out_ready: pulse position_update_valid and exposure_update_valid in the same cycle and increment accept_count.
- After the send handshake, go to REQ directly if the FIFO is non-empty (popping it), otherwise go to IDLE.
- Only one order is in flight between REQ and SEND. Later orders wait in the FIFO.
- Counters saturate at all-ones; they never wrap.
- Update data outputs are 0 whenever their valid is 0.

## Timing
- Reset values:
  - in_ready=1
  - trade_valid=0, trade_data=0
  - out_valid=0, out_qty=0, out_notional=0
  - both update valids 0, both update data 0
  - both counters 0
  - state IDLE, FIFO empty
- Latency from accepted input (cycle 0) with the FIFO previously empty and out_ready=1:
  - trade_valid in cycle 2 (cycle 1 is IDLE popping the FIFO)
  - decision in cycle 3
  - out_valid and update pulses in cycle 4
- Back-to-back orders: the next trade_valid is the cycle after the send handshake. By then the risk checker has absorbed the update pulse, so the next check sees the updated position.
- out_ready low holds SEND indefinitely. There is no timeout. The FIFO keeps accepting until full.
- FIFO full: in_ready=0. A push and pop in the same cycle when full is not possible, because a pop only occurs on state transitions and in_ready is computed from the registered count.
- A simultaneous push and pop with count between 1 and FIFO_DEPTH-1 leaves the count unchanged.
- Reset asserted mid-operation: the in-flight order and the FIFO contents are discarded. No update pulse or counter change occurs in the reset cycle.
- trade_approved is ignored outside DECIDE.

## Configuration
- Macro TRADE_DISPATCHER_COUNTERS_EN.
- Defined: accept_count and reject_count are implemented as described.
- Undefined: both counters are removed and the outputs are tied to 0. All other behaviour is identical.

## Test plan
- Approve path: push qty=100, notional=5000 with trade_approved=1 and out_ready=1.
  - trade_valid pulses in cycle 2 with trade_data=100.
  - out_valid in cycle 4.
  - position_update=100 and exposure_update=5000 pulse in cycle 4.
  - accept_count=1.
- Reject path: push qty=200 with trade_approved=0 in the DECIDE cycle.
  - No out_valid and no update pulses.
  - reject_count=1, state back to IDLE in the next cycle.
- Backpressure: push FIFO_DEPTH+2 orders while out_ready=0 and approvals are 1.
  - The first order sticks in SEND.
  - in_ready drops after FIFO_DEPTH further pushes.
  - Releasing out_ready drains all orders in push order with correct qty/notional.
- Mixed decisions: push 3 orders with approvals 1,0,1.
  - Exactly 2 sends, accept_count=2, reject_count=1.
  - Update pulses carry the 1st and 3rd quantities.
- Saturation: with CNT_W=4, reject 17 orders. reject_count stays at 15.
- Reset mid-SEND: assert rst_n=0 while out_valid=1.
  - The next cycle shows all outputs at their reset values and in_ready=1.
  - No update pulse was emitted.

Source files
------------

// File: rtl/trade_dispatcher_if.sv
// Bus bundle for trade_dispatcher: strategy input, risk-check request/decision,
// exchange output handshake, position/exposure update pulses and counters.
interface trade_dispatcher_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_qty;
   logic [31:0]      in_notional;
   logic [31:0]      trade_data;
   logic             trade_valid;
   logic             trade_approved;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_qty;
   logic [31:0]      out_notional;
   logic [31:0]      position_update;
   logic             position_update_valid;
   logic [31:0]      exposure_update;
   logic             exposure_update_valid;
   logic [CNT_W-1:0] accept_count;
   logic [CNT_W-1:0] reject_count;

   // The dispatcher initiates trade requests, so it owns the master side.
   modport master (
      input  in_valid, in_qty, in_notional, trade_approved, out_ready,
      output in_ready, trade_data, trade_valid, out_valid, out_qty, out_notional,
             position_update, position_update_valid,
             exposure_update, exposure_update_valid,
             accept_count, reject_count
   );

   modport slave (
      output in_valid, in_qty, in_notional, trade_approved, out_ready,
      input  in_ready, trade_data, trade_valid, out_valid, out_qty, out_notional,
             position_update, position_update_valid,
             exposure_update, exposure_update_valid,
             accept_count, reject_count
   );
endinterface

// File: rtl/trade_dispatcher.sv
// Order FIFO plus one-at-a-time risk-check/send sequencer.
// Optional accept/reject counters: define TRADE_DISPATCHER_COUNTERS_EN.
module trade_dispatcher #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input logic                clk,
   input logic                rst_n,
   trade_dispatcher_if.master bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DECIDE, ST_SEND} state_t;

   logic [63:0]      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic [31:0]      r_qty;
   logic [31:0]      r_notional;
   state_t           r_state;
   state_t           w_next_state;
   logic             w_push;
   logic             w_pop;
   logic             w_send;
   logic             w_fire;
   logic             w_fifo_empty;

   assign w_fifo_empty = (r_count == '0);
   assign bus.in_ready = (r_count != DEPTH_C);
   assign w_push       = bus.in_valid && bus.in_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; an entry is only ever read after
   // it has been written, so clearing it would buy nothing.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {bus.in_qty, bus.in_notional};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_qty      <= '0;
         r_notional <= '0;
      end else if (w_pop) begin
         {r_qty, r_notional} <= r_mem[r_rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_next_state     = r_state;
      w_pop            = 1'b0;
      w_send           = 1'b0;
      bus.trade_valid  = 1'b0;
      bus.trade_data   = '0;
      bus.out_valid    = 1'b0;
      bus.out_qty      = '0;
      bus.out_notional = '0;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop        = 1'b1;
               w_next_state = ST_REQ;
            end
         end
         ST_REQ: begin
            bus.trade_valid = 1'b1;
            bus.trade_data  = r_qty;
            w_next_state    = ST_DECIDE;
         end
         ST_DECIDE: begin
            w_next_state = bus.trade_approved ? ST_SEND : ST_IDLE;
         end
         ST_SEND: begin
            bus.out_valid    = 1'b1;
            bus.out_qty      = r_qty;
            bus.out_notional = r_notional;
            if (bus.out_ready) begin
               w_send = 1'b1;
               // Chain straight into the next check when an order is waiting.
               if (!w_fifo_empty) begin
                  w_pop        = 1'b1;
                  w_next_state = ST_REQ;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // A send in the reset cycle is discarded, so it must not reach the risk checker.
   assign w_fire                    = w_send && rst_n;
   assign bus.position_update_valid = w_fire;
   assign bus.exposure_update_valid = w_fire;
   assign bus.position_update       = w_fire ? r_qty      : '0;
   assign bus.exposure_update       = w_fire ? r_notional : '0;

`ifdef TRADE_DISPATCHER_COUNTERS_EN
   logic [CNT_W-1:0] r_accept_cnt;
   logic [CNT_W-1:0] r_reject_cnt;
   logic             w_reject;

   assign w_reject = (r_state == ST_DECIDE) && !bus.trade_approved;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_accept_cnt <= '0;
         r_reject_cnt <= '0;
      end else begin
         if (w_fire && (r_accept_cnt != '1))
            r_accept_cnt <= r_accept_cnt + CNT_W'(1);
         if (w_reject && (r_reject_cnt != '1))
            r_reject_cnt <= r_reject_cnt + CNT_W'(1);
      end
   end

   assign bus.accept_count = r_accept_cnt;
   assign bus.reject_count = r_reject_cnt;
`else
   assign bus.accept_count = {CNT_W{1'b0}};
   assign bus.reject_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_trade_dispatcher.sv
// Directed bench for trade_dispatcher: per-cycle vector table for the approve and
// reject paths, then queue-driven sequences for mixed, backpressure, saturation, reset.
module tb_trade_dispatcher;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 4;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef TRADE_DISPATCHER_COUNTERS_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic        vld;
      logic [31:0] qty;
      logic [31:0] notl;
      logic        appr;
      logic        ordy;
      logic        e_tv;
      logic [31:0] e_td;
      logic        e_ov;
      logic [31:0] e_oq;
      logic [31:0] e_on;
      logic        e_pv;
      logic [31:0] e_pos;
      logic [31:0] e_exp;
      logic        e_rdy;
      int          e_acc;
      int          e_rej;
   } vec_t;

   typedef struct {
      logic [31:0] qty;
      logic [31:0] notl;
   } order_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   trade_dispatcher_if #(.CNT_W(CNT_W)) bus ();

   trade_dispatcher #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_sends  = 0;
   int          n_pushed = 0;
   int          m_acc    = 0;
   int          m_rej    = 0;
   bit          saw_tv   = 1'b0;
   logic        tb_out_ready = 1'b1;
   order_t      push_q[$];
   order_t      exp_q[$];
   logic [31:0] chk_q[$];
   bit          appr_q[$];
   vec_t        vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   function automatic int cnt_exp(input int v);
      return CNT_EN ? v : 0;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, " in_ready"},     64'(bus.in_ready), 64'd1);
      check({tag, " trade_valid"},  64'(bus.trade_valid), 64'd0);
      check({tag, " trade_data"},   64'(bus.trade_data), 64'd0);
      check({tag, " out_valid"},    64'(bus.out_valid), 64'd0);
      check({tag, " out_qty"},      64'(bus.out_qty), 64'd0);
      check({tag, " out_notional"}, 64'(bus.out_notional), 64'd0);
      check({tag, " pos_valid"},    64'(bus.position_update_valid), 64'd0);
      check({tag, " pos_data"},     64'(bus.position_update), 64'd0);
      check({tag, " exp_valid"},    64'(bus.exposure_update_valid), 64'd0);
      check({tag, " exp_data"},     64'(bus.exposure_update), 64'd0);
      check({tag, " accept_count"}, 64'(bus.accept_count), 64'd0);
      check({tag, " reject_count"}, 64'(bus.reject_count), 64'd0);
   endtask

   task automatic add_order(input logic [31:0] qty, input logic [31:0] notl, input bit approve);
      order_t o;
      o.qty  = qty;
      o.notl = notl;
      push_q.push_back(o);
      chk_q.push_back(qty);
      appr_q.push_back(approve);
      if (approve) begin
         exp_q.push_back(o);
         m_acc = sat_inc(m_acc);
      end else begin
         m_rej = sat_inc(m_rej);
      end
   endtask

   // Called at posedge+1; returns at posedge+1. Drives pushes, answers each
   // trade request in the following cycle and scores every send pulse.
   task automatic run_traffic(input int max_cycles, input bit must_drain);
      int cyc = 0;
      bit done = 1'b0;
      while (!done) begin
         bus.out_ready = tb_out_ready;
         if (push_q.size() != 0) begin
            bus.in_valid    = 1'b1;
            bus.in_qty      = push_q[0].qty;
            bus.in_notional = push_q[0].notl;
         end else begin
            bus.in_valid    = 1'b0;
            bus.in_qty      = '0;
            bus.in_notional = '0;
         end
         if (saw_tv) begin
            if (appr_q.size() != 0) bus.trade_approved = appr_q.pop_front();
            else                    bus.trade_approved = 1'b0;
         end else begin
            bus.trade_approved = 1'($urandom_range(0, 1));
         end
         saw_tv = 1'b0;
         #1;
         if (bus.trade_valid) begin
            saw_tv = 1'b1;
            if (chk_q.size() == 0) check("unexpected trade_valid", 64'd1, 64'd0);
            else                   check("trade_data", 64'(bus.trade_data), 64'(chk_q.pop_front()));
         end
         if (bus.position_update_valid || bus.exposure_update_valid) begin
            n_sends++;
            check("pos_valid on send", 64'(bus.position_update_valid), 64'd1);
            check("exp_valid on send", 64'(bus.exposure_update_valid), 64'd1);
            if (exp_q.size() == 0) begin
               check("unexpected send", 64'd1, 64'd0);
            end else begin
               order_t e = exp_q.pop_front();
               check("position_update", 64'(bus.position_update), 64'(e.qty));
               check("exposure_update", 64'(bus.exposure_update), 64'(e.notl));
               check("out_qty",         64'(bus.out_qty), 64'(e.qty));
               check("out_notional",    64'(bus.out_notional), 64'(e.notl));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            void'(push_q.pop_front());
            n_pushed++;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (must_drain && push_q.size() == 0 && chk_q.size() == 0 &&
             appr_q.size() == 0 && exp_q.size() == 0 && !saw_tv) begin
            done = 1'b1;
         end else if (cyc >= max_cycles) begin
            if (must_drain) check("drain cycle budget", 64'(cyc), 64'(max_cycles - 1));
            done = 1'b1;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int base_sends;
      bus.in_valid       = 1'b0;
      bus.in_qty         = '0;
      bus.in_notional    = '0;
      bus.trade_approved = 1'b0;
      bus.out_ready      = 1'b1;

      //                vld qty  notl  ap or | tv td   ov oq   on    pv pos  exp   rdy acc rej
      vecs[0]  = '{1'b1, 100, 5000, 1'b0, 1'b1, 1'b0,   0, 1'b0,   0,    0, 1'b0,   0,    0, 1'b1, 0, 0};
      vecs[1]  = '{1'b0,   0,    0, 1'b0, 1'b1, 1'b0,   0, 1'b0,   0,    0, 1'b0,   0,    0, 1'b1, 0, 0};
      vecs[2]  = '{1'b0,   0,    0, 1'b0, 1'b1, 1'b1, 100, 1'b0,   0,    0, 1'b0,   0,    0, 1'b1, 0, 0};
      vecs[3]  = '{1'b0,   0,    0, 1'b1, 1'b1, 1'b0,   0, 1'b0,   0,    0, 1'b0,   0,    0, 1'b1, 0, 0};
      vecs[4]  = '{1'b0,   0,    0, 1'b0, 1'b1, 1'b0,   0, 1'b1, 100, 5000, 1'b1, 100, 5000, 1'b1, 0, 0};
      vecs[5]  = '{1'b0,   0,    0, 1'b0, 1'b1, 1'b0,   0, 1'b0,   0,    0, 1'b0,   0,    0, 1'b1, 1, 0};
      vecs[6]  = '{1'b1, 200,    7, 1'b0, 1'b1, 1'b0,   0, 1'b0,   0,    0, 1'b0,   0,    0, 1'b1, 1, 0};
      vecs[7]  = '{1'b0,   0,    0, 1'b1, 1'b1, 1'b0,   0, 1'b0,   0,    0, 1'b0,   0,    0, 1'b1, 1, 0};
      vecs[8]  = '{1'b0,   0,    0, 1'b1, 1'b1, 1'b1, 200, 1'b0,   0,    0, 1'b0,   0,    0, 1'b1, 1, 0};
      vecs[9]  = '{1'b0,   0,    0, 1'b0, 1'b1, 1'b0,   0, 1'b0,   0,    0, 1'b0,   0,    0, 1'b1, 1, 0};
      vecs[10] = '{1'b0,   0,    0, 1'b1, 1'b1, 1'b0,   0, 1'b0,   0,    0, 1'b0,   0,    0, 1'b1, 1, 1};
      vecs[11] = '{1'b0,   0,    0, 1'b0, 1'b1, 1'b0,   0, 1'b0,   0,    0, 1'b0,   0,    0, 1'b1, 1, 1};

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Approve path (vectors 0-5) then reject path (6-11), cycle by cycle.
      for (int i = 0; i < 12; i++) begin
         bus.in_valid       = vecs[i].vld;
         bus.in_qty         = vecs[i].qty;
         bus.in_notional    = vecs[i].notl;
         bus.trade_approved = vecs[i].appr;
         bus.out_ready      = vecs[i].ordy;
         #1;
         check($sformatf("v%0d trade_valid", i),  64'(bus.trade_valid), 64'(vecs[i].e_tv));
         check($sformatf("v%0d trade_data", i),   64'(bus.trade_data), 64'(vecs[i].e_td));
         check($sformatf("v%0d out_valid", i),    64'(bus.out_valid), 64'(vecs[i].e_ov));
         check($sformatf("v%0d out_qty", i),      64'(bus.out_qty), 64'(vecs[i].e_oq));
         check($sformatf("v%0d out_notional", i), 64'(bus.out_notional), 64'(vecs[i].e_on));
         check($sformatf("v%0d pos_valid", i),    64'(bus.position_update_valid), 64'(vecs[i].e_pv));
         check($sformatf("v%0d exp_valid", i),    64'(bus.exposure_update_valid), 64'(vecs[i].e_pv));
         check($sformatf("v%0d pos_data", i),     64'(bus.position_update), 64'(vecs[i].e_pos));
         check($sformatf("v%0d exp_data", i),     64'(bus.exposure_update), 64'(vecs[i].e_exp));
         check($sformatf("v%0d in_ready", i),     64'(bus.in_ready), 64'(vecs[i].e_rdy));
         check($sformatf("v%0d accept_count", i), 64'(bus.accept_count), 64'(cnt_exp(vecs[i].e_acc)));
         check($sformatf("v%0d reject_count", i), 64'(bus.reject_count), 64'(cnt_exp(vecs[i].e_rej)));
         @(posedge clk);
         #1;
      end
      m_acc = 1;
      m_rej = 1;

      // Mixed decisions 1,0,1.
      tb_out_ready = 1'b1;
      base_sends = n_sends;
      add_order(300, 3000, 1'b1);
      add_order(301, 3001, 1'b0);
      add_order(302, 3002, 1'b1);
      run_traffic(200, 1'b1);
      check("mixed send count", 64'(n_sends - base_sends), 64'd2);
      check("mixed accept_count", 64'(bus.accept_count), 64'(cnt_exp(m_acc)));
      check("mixed reject_count", 64'(bus.reject_count), 64'(cnt_exp(m_rej)));

      // Backpressure: first order parks in SEND, FIFO fills, then drains in order.
      tb_out_ready = 1'b0;
      base_sends = n_sends;
      n_pushed = 0;
      for (int k = 0; k < FIFO_DEPTH + 2; k++) add_order(32'(10 + k), 32'(1000 + k), 1'b1);
      run_traffic(12, 1'b0);
      #1;
      check("bp accepted pushes", 64'(n_pushed), 64'(1 + FIFO_DEPTH));
      check("bp in_ready", 64'(bus.in_ready), 64'd0);
      check("bp out_valid held", 64'(bus.out_valid), 64'd1);
      check("bp out_qty held", 64'(bus.out_qty), 64'd10);
      check("bp out_notional held", 64'(bus.out_notional), 64'd1000);
      check("bp no send while stalled", 64'(n_sends - base_sends), 64'd0);
      tb_out_ready = 1'b1;
      run_traffic(300, 1'b1);
      check("bp send count", 64'(n_sends - base_sends), 64'(FIFO_DEPTH + 2));
      check("bp accept_count", 64'(bus.accept_count), 64'(cnt_exp(m_acc)));

      // Reject saturation at all-ones.
      for (int k = 0; k < 17; k++) add_order(32'(500 + k), 32'(k), 1'b0);
      run_traffic(600, 1'b1);
      check("sat reject_count", 64'(bus.reject_count), 64'(cnt_exp(m_rej)));
      check("sat accept_count", 64'(bus.accept_count), 64'(cnt_exp(m_acc)));

      // Reset while an approved order is presented; the release would otherwise fire.
      tb_out_ready = 1'b0;
      add_order(77, 88, 1'b1);
      add_order(78, 89, 1'b1);
      run_traffic(8, 1'b0);
      #1;
      check("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
      check("pre-reset out_qty", 64'(bus.out_qty), 64'd77);
      rst_n = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("reset-cycle pos_valid", 64'(bus.position_update_valid), 64'd0);
      check("reset-cycle exp_valid", 64'(bus.exposure_update_valid), 64'd0);
      @(posedge clk);
      #1;
      check_reset_outputs("mid-send reset");
      rst_n = 1'b1;
      push_q.delete();
      exp_q.delete();
      chk_q.delete();
      appr_q.delete();
      saw_tv = 1'b0;
      m_acc = 0;
      m_rej = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("post-reset idle %0d", k), 64'(bus.trade_valid), 64'd0);
      end
      tb_out_ready = 1'b1;
      add_order(55, 66, 1'b1);
      run_traffic(100, 1'b1);
      check("post-reset accept_count", 64'(bus.accept_count), 64'(cnt_exp(m_acc)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
